// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse stretcher: the FSM state encoding and the
// elaboration-time helpers used to size its counter.
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        GAP  = 2'b10
    } state_t;

    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits++;
            rem = rem >> 1;
        end
        return bits;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hold_counter.sv
// Loadable down-counter for the hold and gap phases. It saturates at zero,
// and a load takes priority over a decrement.
module hold_counter #(
    parameter int W = 2
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    // NOTE: sequential state is updated with <= only, so every flop samples
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Stretches single-cycle event strobes into a level held for HOLD_CYCLES,
// followed by a low gap of GAP_CYCLES, with a one-deep pending slot.
module pulse_stretch
    import pulse_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int RETRIGGER   = 0
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic Pulse,
    input  logic ClearOverrun,
    output logic Level,
    output logic Busy,
    output logic Overrun
);

    localparam int CW = clog2(max3(HOLD_CYCLES, GAP_CYCLES, 2));
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t          state, state_next;
    logic            pending, pending_next;
    logic            overrun_next;
    logic            load, dec, zero;
    logic [CW-1:0]   load_value;
    logic [CW-1:0]   cnt;
    logic            consume;  // the pending pulse starts a hold at this edge
    logic            queue;    // the incoming pulse must wait in the slot

    hold_counter #(.W(CW)) u_counter (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .load       (load),
        .load_value (load_value),
        .dec        (dec),
        .cnt        (cnt),
        .zero       (zero)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_value = HOLD_LOAD;
        dec        = 1'b0;
        consume    = 1'b0;
        queue      = 1'b0;

        unique case (state)
            IDLE: begin
                if (Pulse) begin
                    state_next = HOLD;
                    load       = 1'b1;
                end
            end
            HOLD: begin
                if ((RETRIGGER != 0) && Pulse) begin
                    load = 1'b1;
                end else if (!zero) begin
                    dec   = 1'b1;
                    queue = Pulse;
                end else if (GAP_CYCLES > 0) begin
                    state_next = GAP;
                    load       = 1'b1;
                    load_value = GAP_LOAD;
                    queue      = Pulse;
                end else if (pending || Pulse) begin
                    // Back-to-back hold with no gap; a fresh pulse refills the slot.
                    load    = 1'b1;
                    consume = pending;
                    queue   = pending && Pulse;
                end else begin
                    state_next = IDLE;
                end
            end
            GAP: begin
                if (!zero) begin
                    dec   = 1'b1;
                    queue = Pulse;
                end else if (pending || Pulse) begin
                    state_next = HOLD;
                    load       = 1'b1;
                    consume    = pending;
                    queue      = pending && Pulse;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        pending_next = queue ? 1'b1 : (consume ? 1'b0 : pending);

        // A pulse is lost when it needs the slot but the slot stays occupied.
        if (queue && pending && !consume) begin
            overrun_next = 1'b1;
        end else if (ClearOverrun) begin
            overrun_next = 1'b0;
        end else begin
            overrun_next = Overrun;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state   <= IDLE;
            pending <= 1'b0;
            Overrun <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            Overrun <= overrun_next;
        end
    end

    assign Level = (state == HOLD);
    assign Busy  = (state != IDLE) || pending;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch: default, retrigger and zero-gap instances
// share stimulus; each task checks the instance its scenario targets.
module tb_pulse_stretch;

    logic Clock;
    logic Resetn;
    logic Pulse;
    logic ClearOverrun;

    logic level0, busy0, ovr0;
    logic level1, busy1, ovr1;
    logic level2, busy2, ovr2;

    int n_checks;
    int n_fail;

    pulse_stretch dut0 (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .Pulse        (Pulse),
        .ClearOverrun (ClearOverrun),
        .Level        (level0),
        .Busy         (busy0),
        .Overrun      (ovr0)
    );

    pulse_stretch #(.RETRIGGER(1)) dut1 (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .Pulse        (Pulse),
        .ClearOverrun (ClearOverrun),
        .Level        (level1),
        .Busy         (busy1),
        .Overrun      (ovr1)
    );

    pulse_stretch #(.GAP_CYCLES(0)) dut2 (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .Pulse        (Pulse),
        .ClearOverrun (ClearOverrun),
        .Level        (level2),
        .Busy         (busy2),
        .Overrun      (ovr2)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Leaves all instances idle, one time unit after a rising edge.
    task automatic apply_reset();
        Pulse        = 1'b0;
        ClearOverrun = 1'b0;
        Resetn       = 1'b0;
        #3;
        Resetn = 1'b1;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Pulse        = 1'b0;
        ClearOverrun = 1'b0;
        Resetn       = 1'b0;
        #2;
        n_checks++;
        if ({level0, busy0, ovr0, level1, busy1, ovr1, level2, busy2, ovr2} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {level0, busy0, ovr0, level1, busy1, ovr1, level2, busy2, ovr2});
        end
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_single();
        bit [15:0] pulses   = 16'h0001;
        bit [15:0] exp_lvl  = 16'h000F;
        bit [15:0] exp_busy = 16'h003F;
        apply_reset();
        for (int e = 0; e < 8; e++) begin
            Pulse = pulses[e];
            @(posedge Clock);
            #1;
            Pulse = 1'b0;
            n_checks++;
            if (level0 !== exp_lvl[e]) begin
                n_fail++;
                $display("FAIL single_level edge %0d: got %b expected %b", e, level0, exp_lvl[e]);
            end
            n_checks++;
            if (busy0 !== exp_busy[e]) begin
                n_fail++;
                $display("FAIL single_busy edge %0d: got %b expected %b", e, busy0, exp_busy[e]);
            end
        end
    endtask

    task automatic test_pending();
        bit [15:0] pulses  = 16'h0005;
        bit [15:0] exp_lvl = 16'h03CF;
        apply_reset();
        for (int e = 0; e < 12; e++) begin
            Pulse = pulses[e];
            @(posedge Clock);
            #1;
            Pulse = 1'b0;
            n_checks++;
            if (level0 !== exp_lvl[e]) begin
                n_fail++;
                $display("FAIL pending_level edge %0d: got %b expected %b", e, level0, exp_lvl[e]);
            end
            if (e == 2) begin
                n_checks++;
                if (dut0.pending !== 1'b1) begin
                    n_fail++;
                    $display("FAIL pending_set edge 2: got %b expected 1", dut0.pending);
                end
            end
        end
        n_checks++;
        if (ovr0 !== 1'b0) begin
            n_fail++;
            $display("FAIL pending_no_overrun: got %b expected 0", ovr0);
        end
    endtask

    task automatic test_overrun();
        bit [15:0] pulses  = 16'h000D;
        bit [15:0] exp_lvl = 16'h03CF;
        apply_reset();
        for (int e = 0; e < 12; e++) begin
            Pulse = pulses[e];
            @(posedge Clock);
            #1;
            Pulse = 1'b0;
            n_checks++;
            if (level0 !== exp_lvl[e]) begin
                n_fail++;
                $display("FAIL overrun_level edge %0d: got %b expected %b", e, level0, exp_lvl[e]);
            end
            n_checks++;
            if (ovr0 !== (e >= 3)) begin
                n_fail++;
                $display("FAIL overrun_flag edge %0d: got %b expected %b", e, ovr0, (e >= 3));
            end
        end
        ClearOverrun = 1'b1;
        @(posedge Clock);
        #1;
        ClearOverrun = 1'b0;
        n_checks++;
        if (ovr0 !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear edge 12: got %b expected 0", ovr0);
        end
        n_checks++;
        if (busy0 !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_idle edge 12: busy got %b expected 0", busy0);
        end
    endtask

    // Set and clear land on the same edge: the set must win.
    task automatic test_overrun_priority();
        apply_reset();
        for (int e = 0; e < 3; e++) begin
            Pulse        = 1'b1;
            ClearOverrun = (e == 2);
            @(posedge Clock);
            #1;
        end
        Pulse        = 1'b0;
        ClearOverrun = 1'b0;
        n_checks++;
        if (ovr0 !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set_wins: got %b expected 1", ovr0);
        end
        ClearOverrun = 1'b1;
        @(posedge Clock);
        #1;
        ClearOverrun = 1'b0;
        n_checks++;
        if (ovr0 !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear_alone: got %b expected 0", ovr0);
        end
    endtask

    task automatic test_retrigger();
        bit [15:0] pulses  = 16'h0009;
        bit [15:0] exp_lvl = 16'h007F;
        apply_reset();
        for (int e = 0; e < 10; e++) begin
            Pulse = pulses[e];
            @(posedge Clock);
            #1;
            Pulse = 1'b0;
            n_checks++;
            if (level1 !== exp_lvl[e]) begin
                n_fail++;
                $display("FAIL retrig_level edge %0d: got %b expected %b", e, level1, exp_lvl[e]);
            end
            n_checks++;
            if (dut1.pending !== 1'b0) begin
                n_fail++;
                $display("FAIL retrig_pending edge %0d: got %b expected 0", e, dut1.pending);
            end
        end
    endtask

    task automatic test_gap_zero();
        bit [15:0] pulses  = 16'h0009;
        bit [15:0] exp_lvl = 16'h00FF;
        apply_reset();
        for (int e = 0; e < 10; e++) begin
            Pulse = pulses[e];
            @(posedge Clock);
            #1;
            Pulse = 1'b0;
            n_checks++;
            if (level2 !== exp_lvl[e]) begin
                n_fail++;
                $display("FAIL gap0_level edge %0d: got %b expected %b", e, level2, exp_lvl[e]);
            end
            if (e == 8) begin
                n_checks++;
                if (busy2 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gap0_idle edge 8: busy got %b expected 0", busy2);
                end
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        bit [15:0] exp_lvl = 16'h000F;
        apply_reset();
        for (int e = 0; e < 3; e++) begin
            Pulse = 1'b1;
            @(posedge Clock);
            #1;
        end
        Pulse = 1'b0;
        n_checks++;
        if ({level0, busy0, ovr0} !== 3'b111) begin
            n_fail++;
            $display("FAIL pre_reset_state: got %b expected 111", {level0, busy0, ovr0});
        end
        #2;
        Resetn = 1'b0;
        #1;
        n_checks++;
        if ({level0, busy0, ovr0} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected 000", {level0, busy0, ovr0});
        end
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        for (int e = 0; e < 6; e++) begin
            Pulse = (e == 0);
            @(posedge Clock);
            #1;
            Pulse = 1'b0;
            n_checks++;
            if (level0 !== exp_lvl[e]) begin
                n_fail++;
                $display("FAIL post_reset_level edge %0d: got %b expected %b", e, level0, exp_lvl[e]);
            end
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        Resetn       = 1'b1;
        Pulse        = 1'b0;
        ClearOverrun = 1'b0;
        test_reset();
        test_single();
        test_pending();
        test_overrun();
        test_overrun_priority();
        test_retrigger();
        test_gap_zero();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
